apb4_master: RTL

Single-outstanding APB4 initiator that turns a simple valid/ready request/response port into APB4 SETUP/ACCESS transfers. It drives the master side of the peripheral bus (PSEL, PADDR, PRDATA/PREADY/PSLVERR return) that the APB slave mux decodes. It sits behind a CPU-side bridge or DMA engine and adds a programmable PREADY timeout so a hung slave cannot stall the system.

---
 rtl/apb4_master.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/apb4_master.sv
// rtl/apb4_master.sv - single-outstanding APB4 initiator with PREADY timeout
//
// Purpose:
//   Converts a valid/ready request port into APB4 SETUP/ACCESS transfers and
//   returns the outcome on a valid/ready response port. A wait counter aborts
//   a transfer whose slave never raises PREADY.
//
// Ports:
//   PCLK, PRESETn                      clock (rising edge), async active-low reset
//   req_valid/req_ready                request handshake
//   req_write/addr/wdata/strb/prot     request payload
//   rsp_valid/rsp_ready                response handshake
//   rsp_rdata/rsp_err/rsp_timeout      response payload
//   PSEL/PENABLE/PADDR/PWRITE/
//   PWDATA/PSTRB/PPROT                 APB4 master outputs
//   PRDATA/PREADY/PSLVERR              APB4 slave returns

module apb4_master #(
  parameter int PADDR_SIZE = 16,
  parameter int PDATA_SIZE = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [PADDR_SIZE-1:0]   req_addr,
  input  logic [PDATA_SIZE-1:0]   req_wdata,
  input  logic [PDATA_SIZE/8-1:0] req_strb,
  input  logic [2:0]              req_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [PDATA_SIZE-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [PADDR_SIZE-1:0]   PADDR,
  output logic                    PWRITE,
  output logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [PDATA_SIZE/8-1:0] PSTRB,
  output logic [2:0]              PPROT,
  input  logic [PDATA_SIZE-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int STRB_W = PDATA_SIZE / 8;
  localparam int CNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_in_access;
  logic             w_done;
  logic             w_timeout_hit;

  // Handshake/bus controls are pure decodes of the state register, so no
  // APB input can reach them combinationally and reset clears them at once.
  assign req_ready   = (r_state == S_IDLE);
  assign rsp_valid   = (r_state == S_RESP);
  assign PSEL        = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign PENABLE     = (r_state == S_ACCESS);

  assign w_accept      = req_valid && req_ready;
  assign w_in_access   = (r_state == S_ACCESS);
  assign w_done        = w_in_access && PREADY;
  // PREADY has priority: the timeout only fires on a cycle the slave is not ready.
  assign w_timeout_hit = (TIMEOUT != 0) && w_in_access && !PREADY && (r_cnt == CNT_LAST);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (w_done || w_timeout_hit) w_next = S_RESP;
      S_RESP:   if (rsp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Wait counter: cleared in SETUP so it reads 0 on the first ACCESS cycle.
  // Saturates so a disabled timeout (TIMEOUT=0) can never wrap it.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_cnt <= '0;
    end else if (w_in_access && !PREADY && !w_timeout_hit && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Request payload is captured only on acceptance, so the APB outputs stay
  // stable across SETUP/ACCESS and keep their last values afterwards.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      PSTRB  <= '0;
      PPROT  <= '0;
    end else if (w_accept) begin
      PADDR  <= req_addr;
      PWRITE <= req_write;
      PWDATA <= req_wdata;
      PSTRB  <= req_write ? req_strb : {STRB_W{1'b0}};
      PPROT  <= req_prot;
    end
  end

  // Response fields only change when ACCESS ends, which keeps them stable
  // throughout RESP regardless of what the slave does afterwards.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (w_done) begin
      rsp_rdata   <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
      rsp_err     <= PSLVERR;
      rsp_timeout <= 1'b0;
    end else if (w_timeout_hit) begin
      rsp_rdata   <= '0;
      rsp_err     <= 1'b1;
      rsp_timeout <= 1'b1;
    end
  end

endmodule
